window_alignment_stream: RTL and testbench

//  Parametrised successor to the window-alignment write path. Accepts an integral-image word stream

---
 rtl/window_alignment_stream_pkg.sv | 19 +
 rtl/window_alignment_stream_if.sv | 17 +
 rtl/window_alignment_stream_packer.sv | 59 +++++
 rtl/window_alignment_stream.sv | 166 ++++++++++++++++
 tb/tb_window_alignment_stream.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/window_alignment_stream_pkg.sv
// Shared constants and types for the window-alignment write path.
package pkg_windowAlignment;

  localparam int unsigned WORD_SIZE   = 32;
  localparam int unsigned WORDS       = 4;
  localparam int unsigned WINDOW_DIM  = 32;
  localparam int unsigned INDEX_WIDTH = $clog2(WINDOW_DIM);
  localparam int unsigned ADDR_WIDTH  = INDEX_WIDTH;
  localparam int unsigned BLOCKS      = (WINDOW_DIM + WORDS - 1) / WORDS;

  typedef logic [WORDS-1:0][WORD_SIZE-1:0] block_t;

  typedef enum logic [1:0] {
    SKIP  = 2'd0,
    PACK  = 2'd1,
    FLUSH = 2'd2
  } wa_state_e;

endpackage

// File: rtl/window_alignment_stream_if.sv
// Window-cache write port bundle: address, packed block, write strobe and backpressure.
interface intf_windowAlignment #(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned WORDS       = 4,
  parameter int unsigned INDEX_WIDTH = 5
) ();

  logic [INDEX_WIDTH-1:0]            waddrY;
  logic [INDEX_WIDTH-1:0]            waddrBlock;
  logic [WORDS-1:0][WORD_SIZE-1:0]   wdata;
  logic                              we;
  logic                              wready;

  modport source (output waddrY, output waddrBlock, output wdata, output we, input wready);
  modport sink   (input waddrY, input waddrBlock, input wdata, input we, output wready);

endinterface

// File: rtl/window_alignment_stream_packer.sv
// Slot counter and accumulator that gathers WORDS words into one block.
// Unfilled slots are always held at zero, so the accumulator doubles as the zero-padded flush block.
module wa_block_packer
  import pkg_windowAlignment::*;
#(
  parameter int unsigned WORD_SIZE = pkg_windowAlignment::WORD_SIZE,
  parameter int unsigned WORDS     = pkg_windowAlignment::WORDS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear_i,
  input  logic                            push_i,
  input  logic [WORD_SIZE-1:0]            data_i,
  output logic                            last_slot_o,
  output logic [WORDS-1:0][WORD_SIZE-1:0] block_o,
  output logic [WORDS-1:0][WORD_SIZE-1:0] pad_o
);

  localparam int unsigned CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [CW-1:0]                   cnt_q, cnt_d, base_cnt;
  logic [WORDS-1:0][WORD_SIZE-1:0] acc_q, acc_d, base_acc;

  // Clear takes effect before a push in the same cycle, so an in_sof word lands in slot 0.
  always_comb begin
    base_cnt    = clear_i ? '0 : cnt_q;
    base_acc    = clear_i ? '0 : acc_q;
    block_o     = base_acc;
    block_o[base_cnt] = data_i;
    last_slot_o = (base_cnt == CW'(WORDS - 1));
    pad_o       = acc_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    if (push_i) begin
      if (last_slot_o) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = base_cnt + 1'b1;
        acc_d = block_o;
      end
    end else if (clear_i) begin
      cnt_d = '0;
      acc_d = '0;
    end
  end

  // Slot counter and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/window_alignment_stream.sv
// Integral-image stream to window-cache writer: drops a per-row leading offset,
// packs WORDS words per block and writes blocks with circular row addressing.
module window_alignment_stream
  import pkg_windowAlignment::*;
#(
  parameter int unsigned WORD_SIZE   = pkg_windowAlignment::WORD_SIZE,
  parameter int unsigned WORDS       = pkg_windowAlignment::WORDS,
  parameter int unsigned WINDOW_DIM  = pkg_windowAlignment::WINDOW_DIM,
  parameter int unsigned INDEX_WIDTH = $clog2(WINDOW_DIM),
  parameter int unsigned OFF_WIDTH   = $clog2(WORDS) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [OFF_WIDTH-1:0]         cfg_offset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WORD_SIZE-1:0]         in_data,
  input  logic                         in_last,
  input  logic                         in_sof,
  output logic [INDEX_WIDTH-1:0]       waddrY,
  output logic [INDEX_WIDTH-1:0]       waddrBlock,
  output logic [WORDS*WORD_SIZE-1:0]   wdata,
  output logic                         we,
  input  logic                         wready,
  output logic                         frame_done
);

  localparam int unsigned NUM_BLOCKS = (WINDOW_DIM + WORDS - 1) / WORDS;
  localparam logic [INDEX_WIDTH-1:0] LAST_ROW = INDEX_WIDTH'(WINDOW_DIM - 1);
  localparam logic [INDEX_WIDTH-1:0] LAST_BLK = INDEX_WIDTH'(NUM_BLOCKS - 1);

  typedef logic [WORDS-1:0][WORD_SIZE-1:0] blk_t;

  wa_state_e              state_q, eff_state;
  logic [OFF_WIDTH-1:0]   skip_cnt_q, off_q, eff_skip, eff_off;
  logic [INDEX_WIDTH-1:0] blk_cnt_q, row_q, eff_blk, eff_row, next_row;
  logic                   row_start_q, row_full_q, eff_full, eff_start;
  logic                   out_free, accept, sof_acc, dropping, push, flush_go;

  logic [INDEX_WIDTH-1:0] waddrY_q, waddrBlock_q;
  blk_t                   wdata_q;
  logic                   we_q, frame_done_q;

  logic                   pk_last;
  blk_t                   pk_block, pk_pad;

  intf_windowAlignment #(
    .WORD_SIZE  (WORD_SIZE),
    .WORDS      (WORDS),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) wr_if ();

  assign wr_if.waddrY     = waddrY_q;
  assign wr_if.waddrBlock = waddrBlock_q;
  assign wr_if.wdata      = wdata_q;
  assign wr_if.we         = we_q;
  assign wr_if.wready     = wready;

  assign waddrY     = wr_if.waddrY;
  assign waddrBlock = wr_if.waddrBlock;
  assign wdata      = wr_if.wdata;
  assign we         = wr_if.we;
  assign frame_done = frame_done_q;

  // Row-start and in_sof override the stored row context, so the accepted word is
  // judged against the freshly sampled offset and the restarted row/block counters.
  always_comb begin
    out_free  = !we_q || wr_if.wready;
    in_ready  = rst_n && (state_q != FLUSH) && out_free;
    accept    = in_valid && in_ready;
    sof_acc   = accept && in_sof;
    eff_start = row_start_q || sof_acc;
    eff_state = eff_start ? SKIP : state_q;
    eff_skip  = eff_start ? '0 : skip_cnt_q;
    eff_off   = eff_start ? cfg_offset : off_q;
    eff_blk   = sof_acc ? '0 : blk_cnt_q;
    eff_row   = sof_acc ? '0 : row_q;
    eff_full  = sof_acc ? 1'b0 : row_full_q;
    dropping  = (eff_state == SKIP) && (eff_skip != eff_off);
    push      = accept && !dropping && !eff_full;
    flush_go  = (state_q == FLUSH) && out_free;
    next_row  = (eff_row == LAST_ROW) ? '0 : eff_row + 1'b1;
  end

  wa_block_packer #(
    .WORD_SIZE(WORD_SIZE),
    .WORDS    (WORDS)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (sof_acc || flush_go),
    .push_i     (push),
    .data_i     (in_data),
    .last_slot_o(pk_last),
    .block_o    (pk_block),
    .pad_o      (pk_pad)
  );

  // Row FSM, row/block counters and the single write output register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SKIP;
      skip_cnt_q   <= '0;
      off_q        <= '0;
      blk_cnt_q    <= '0;
      row_q        <= '0;
      row_start_q  <= 1'b1;
      row_full_q   <= 1'b0;
      waddrY_q     <= '0;
      waddrBlock_q <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= we_q && wr_if.wready && (waddrY_q == LAST_ROW) && (waddrBlock_q == LAST_BLK);
      if (we_q && wr_if.wready) we_q <= 1'b0;

      if (flush_go) begin
        we_q         <= 1'b1;
        waddrY_q     <= row_q;
        waddrBlock_q <= blk_cnt_q;
        wdata_q      <= pk_pad;
        blk_cnt_q    <= '0;
        row_full_q   <= 1'b0;
        row_q        <= next_row;
        state_q      <= SKIP;
        skip_cnt_q   <= '0;
        row_start_q  <= 1'b1;
      end else if (accept) begin
        row_start_q <= 1'b0;
        off_q       <= eff_off;
        row_q       <= eff_row;
        blk_cnt_q   <= eff_blk;
        row_full_q  <= eff_full;
        if (dropping) begin
          state_q    <= SKIP;
          skip_cnt_q <= eff_skip + 1'b1;
        end else begin
          state_q    <= PACK;
          skip_cnt_q <= eff_skip;
          if (push && pk_last) begin
            we_q         <= 1'b1;
            waddrY_q     <= eff_row;
            waddrBlock_q <= eff_blk;
            wdata_q      <= pk_block;
            if (eff_blk == LAST_BLK) row_full_q <= 1'b1;
            else                     blk_cnt_q  <= eff_blk + 1'b1;
          end
        end
        if (in_last) begin
          if (dropping || eff_full || pk_last) begin
            blk_cnt_q   <= '0;
            row_full_q  <= 1'b0;
            row_q       <= next_row;
            state_q     <= SKIP;
            skip_cnt_q  <= '0;
            row_start_q <= 1'b1;
          end else begin
            state_q <= FLUSH;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_window_alignment_stream.sv
// Directed bench for window_alignment_stream with a row-level write model and per-cycle compare.
module tb_window_alignment_stream;

  localparam int W   = 32;
  localparam int N   = 4;
  localparam int DIM = 8;
  localparam int NB  = 2;
  localparam int IW  = 3;
  localparam int OW  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [OW-1:0]     cfg_offset;
  logic              in_valid, in_ready, in_last, in_sof;
  logic [W-1:0]      in_data;
  logic [IW-1:0]     waddrY, waddrBlock;
  logic [N*W-1:0]    wdata;
  logic              we, wready, frame_done;

  typedef struct {
    int             y;
    int             b;
    logic [N*W-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t seen[$];
  int  rises[$];
  int  acc_cyc[$];
  int  checks = 0, failures = 0, cyc = 0, m_row = 0, fd_count = 0;

  logic           exp_fd = 1'b0, prev_stall = 1'b0, prev_we = 1'b0;
  logic [IW-1:0]  prev_y, prev_b;
  logic [N*W-1:0] prev_d;
  wr_t            mon_e;

  window_alignment_stream #(
    .WORD_SIZE (W),
    .WORDS     (N),
    .WINDOW_DIM(DIM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_offset(cfg_offset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_sof    (in_sof),
    .waddrY    (waddrY),
    .waddrBlock(waddrBlock),
    .wdata     (wdata),
    .we        (we),
    .wready    (wready),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_int(string name, integer act, integer req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_vec(string name, logic [N*W-1:0] act, logic [N*W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Row model: kept words are those after the offset, capped at DIM; full blocks are
  // always written, a trailing partial block only when the row is closed by in_last.
  task automatic model_row(int off, int n, int first, bit last, bit sof);
    int k;
    wr_t e;
    if (sof) m_row = 0;
    k = n - off;
    if (k < 0) k = 0;
    if (k > DIM) k = DIM;
    for (int b = 0; b * N < k; b++) begin
      if (!last && (b + 1) * N > k) break;
      e.y = m_row;
      e.b = b;
      e.d = '0;
      for (int s = 0; s < N; s++)
        if (b * N + s < k) e.d[s*W +: W] = 32'(first + off + b * N + s);
      exp_q.push_back(e);
    end
    if (last) m_row = (m_row + 1) % DIM;
  endtask

  task automatic send_row(int off, int n, int first, bit last, bit sof);
    bit r;
    int t, c;
    model_row(off, n, first, last, sof);
    @(posedge clk); #1;
    cfg_offset = OW'(off);
    acc_cyc.delete();
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(first + i);
      in_last  = last && (i == n - 1);
      in_sof   = sof && (i == 0);
      r = 1'b0;
      t = 0;
      c = 0;
      while (!r && t < 60) begin
        @(negedge clk);
        r = in_ready;
        c = cyc;
        @(posedge clk);
        t++;
      end
      #1;
      if (!r) begin
        checks++;
        failures++;
        $display("FAIL handshake_timeout: word %0d never accepted, required acceptance within 60 cycles", i);
        break;
      end
      acc_cyc.push_back(c);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check_int("drain_pending_writes", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic stall3();
    int t = 0;
    while (!we && t < 40) begin
      @(negedge clk);
      t++;
    end
    check_int("stall_we_seen", we, 1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check_int("stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    wready = 1'b1;
  endtask

  // Per-cycle compare of the write port and frame_done against the model queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_we    = 1'b0;
      exp_fd     = 1'b0;
    end else begin
      check_int("frame_done", frame_done, exp_fd);
      if (frame_done) fd_count++;
      exp_fd = 1'b0;
      if (prev_stall) begin
        check_int("hold_we", we, 1);
        check_int("hold_Y", waddrY, prev_y);
        check_int("hold_B", waddrBlock, prev_b);
        check_vec("hold_data", wdata, prev_d);
      end
      if (we && !prev_we) rises.push_back(cyc);
      if (we && wready) begin
        mon_e.y = int'(waddrY);
        mon_e.b = int'(waddrBlock);
        mon_e.d = wdata;
        seen.push_back(mon_e);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got Y%0d B%0d data %h, required no write", waddrY, waddrBlock, wdata);
        end else begin
          mon_e = exp_q.pop_front();
          check_int("write_Y", waddrY, mon_e.y);
          check_int("write_B", waddrBlock, mon_e.b);
          check_vec("write_data", wdata, mon_e.d);
          if (mon_e.y == DIM - 1 && mon_e.b == NB - 1) exp_fd = 1'b1;
        end
      end
      prev_stall = we && !wready;
      prev_we    = we;
      prev_y     = waddrY;
      prev_b     = waddrBlock;
      prev_d     = wdata;
    end
  end

  initial begin
    rst_n      = 1'b0;
    cfg_offset = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    in_sof     = 1'b0;
    wready     = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("reset_we", we, 0);
    check_int("reset_Y", waddrY, 0);
    check_int("reset_B", waddrBlock, 0);
    check_vec("reset_data", wdata, '0);
    check_int("reset_frame_done", frame_done, 0);
    check_int("reset_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_int("post_reset_in_ready", in_ready, 1);

    // 1: offset 0, 8 words, two full blocks; first we one cycle after word 4
    seen.delete();
    rises.delete();
    send_row(0, 8, 1, 1'b1, 1'b0);
    drain();
    check_int("t1_first_we_latency", (rises.size() > 0) ? rises[0] : -1, acc_cyc[3] + 1);
    check_vec("t1_lit_b0", (seen.size() > 0) ? seen[0].d : '0, {32'd4, 32'd3, 32'd2, 32'd1});
    check_vec("t1_lit_b1", (seen.size() > 1) ? seen[1].d : '0, {32'd8, 32'd7, 32'd6, 32'd5});

    // 2: offset 2 drops the first two words
    seen.delete();
    send_row(2, 10, 1, 1'b1, 1'b0);
    drain();
    check_vec("t2_lit_b0", (seen.size() > 0) ? seen[0].d : '0, {32'd6, 32'd5, 32'd4, 32'd3});
    check_vec("t2_lit_b1", (seen.size() > 1) ? seen[1].d : '0, {32'd10, 32'd9, 32'd8, 32'd7});

    // Words past WINDOW_DIM dropped; offset equal to WORDS
    send_row(0, 11, 11, 1'b1, 1'b0);
    send_row(4, 12, 31, 1'b1, 1'b0);
    drain();

    // 3: short row -> zero-padded flush with in_ready low for the flush cycle
    seen.delete();
    send_row(0, 5, 41, 1'b1, 1'b0);
    @(negedge clk);
    check_int("t3_flush_in_ready", in_ready, 0);
    @(negedge clk);
    check_int("t3_after_flush_in_ready", in_ready, 1);
    drain();
    check_vec("t3_lit_pad", (seen.size() > 1) ? seen[1].d : '0, {32'd0, 32'd0, 32'd0, 32'd45});
    check_int("t3_lit_Y", (seen.size() > 1) ? seen[1].y : -1, 4);

    // 4: three cycles of backpressure while a write is pending
    @(posedge clk); #1;
    wready = 1'b0;
    fork
      send_row(0, 8, 51, 1'b1, 1'b0);
      stall3();
    join
    drain();

    // 5: frame from in_sof, wrap to row 0, then mid-row in_sof restart
    send_row(0, 8, 61, 1'b1, 1'b1);
    for (int r = 1; r < DIM; r++) send_row(0, 8, 61 + 8 * r, 1'b1, 1'b0);
    drain();
    check_int("t5_frame_done_once", fd_count, 1);
    seen.delete();
    send_row(0, 8, 200, 1'b1, 1'b0);
    send_row(0, 6, 300, 1'b0, 1'b0);
    send_row(0, 8, 400, 1'b1, 1'b1);
    drain();
    check_int("t5_wrap_Y", (seen.size() > 0) ? seen[0].y : -1, 0);
    check_vec("t5_sof_lit", (seen.size() > 3) ? seen[3].d : '0, {32'd403, 32'd402, 32'd401, 32'd400});
    check_int("t5_frame_done_total", fd_count, 1);

    // 6: asynchronous reset while a write is held
    @(posedge clk); #1;
    wready = 1'b0;
    send_row(0, 4, 500, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_int("t6_rst_we", we, 0);
    check_int("t6_rst_Y", waddrY, 0);
    check_int("t6_rst_B", waddrBlock, 0);
    check_vec("t6_rst_data", wdata, '0);
    check_int("t6_rst_in_ready", in_ready, 0);
    exp_q.delete();
    m_row  = 0;
    wready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen.delete();
    send_row(0, 8, 600, 1'b1, 1'b0);
    drain();
    check_int("t6_restart_Y", (seen.size() > 0) ? seen[0].y : -1, 0);
    check_vec("t6_restart_lit", (seen.size() > 0) ? seen[0].d : '0, {32'd603, 32'd602, 32'd601, 32'd600});

    check_int("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
